sound_player: RTL and testbench

Consumer end of the 2-bit sound-code interface driven by the logo animation block (codes: stop/pong/ping/go). It turns each new code into a timed square-wave tone sequence on a single speaker pin. The block sits between the animation block and the board buzzer, and honours that block's mute flag.

---
 rtl/sound_player.sv | 117 +++++++++++
 tb/tb_sound_player.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sound_player.sv
// Sound-code consumer: plays a timed square-wave tone sequence for each new code
// on the speaker pin. Define SOUND_RETRIG_EN to add the retrig input.
module sound_player #(
  parameter int unsigned PING_HALF = 14204,
  parameter int unsigned PONG_HALF = 28409,
  parameter int unsigned DUR_CYC   = 2500000,
  parameter int unsigned GAP_CYC   = 1250000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] code_sound,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] cur_code
`ifdef SOUND_RETRIG_EN
  ,
  input  logic       retrig
`endif
);

  localparam logic [1:0] CODE_STOP = 2'b00;
  localparam logic [1:0] CODE_PING = 2'b10;
  localparam logic [1:0] CODE_GO   = 2'b11;

  localparam logic [15:0] PING_LIM = 16'(PING_HALF);
  localparam logic [15:0] PONG_LIM = 16'(PONG_HALF);
  localparam logic [23:0] DUR_LAST = 24'(DUR_CYC - 1);
  localparam logic [23:0] GAP_LAST = 24'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, TONE1, GAP, TONE2} state_t;

  state_t      state;
  logic [1:0]  code_q;
  logic [15:0] half_cnt;
  logic [15:0] half_lim;
  logic [23:0] dur_cnt;
  logic        tone_q;
  logic        trig;
  logic        stop_req;

`ifdef SOUND_RETRIG_EN
  assign trig = (code_sound != CODE_STOP) && ((code_sound != code_q) || retrig);
`else
  assign trig = (code_sound != CODE_STOP) && (code_sound != code_q);
`endif
  assign stop_req = (code_sound == CODE_STOP) && (code_q != CODE_STOP);

  assign speaker = tone_q & ~mute;
  assign busy    = (state != IDLE);

  // dur_cnt doubles as the gap counter; GAP never overlaps a tone.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      code_q   <= CODE_STOP;
      cur_code <= CODE_STOP;
      half_cnt <= '0;
      half_lim <= '0;
      dur_cnt  <= '0;
      tone_q   <= 1'b0;
    end else begin
      code_q <= code_sound;
      if (trig) begin
        state    <= TONE1;
        cur_code <= code_sound;
        half_cnt <= '0;
        dur_cnt  <= '0;
        tone_q   <= 1'b0;
        half_lim <= (code_sound == CODE_PING) ? PING_LIM : PONG_LIM;
      end else if (stop_req) begin
        state    <= IDLE;
        cur_code <= CODE_STOP;
        half_cnt <= '0;
        dur_cnt  <= '0;
        tone_q   <= 1'b0;
      end else begin
        case (state)
          TONE1, TONE2: begin
            if (half_cnt == half_lim - 16'd1) begin
              half_cnt <= '0;
              tone_q   <= ~tone_q;
            end else begin
              half_cnt <= half_cnt + 16'd1;
            end
            // Terminal count overrides any toggle landing on the same edge.
            if (dur_cnt == DUR_LAST) begin
              dur_cnt  <= '0;
              half_cnt <= '0;
              tone_q   <= 1'b0;
              if (state == TONE1 && cur_code == CODE_GO) begin
                state <= GAP;
              end else begin
                state    <= IDLE;
                cur_code <= CODE_STOP;
              end
            end else begin
              dur_cnt <= dur_cnt + 24'd1;
            end
          end
          GAP: begin
            if (dur_cnt == GAP_LAST) begin
              dur_cnt  <= '0;
              half_cnt <= '0;
              half_lim <= PING_LIM;
              state    <= TONE2;
            end else begin
              dur_cnt <= dur_cnt + 24'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Scoreboarded bench for sound_player: an offset-based tone model predicts each
// cycle's outputs; a monitor compares them after every rising edge.
module tb_sound_player;

  localparam int PH  = 3;
  localparam int QH  = 5;
  localparam int DUR = 20;
  localparam int GAP = 6;
`ifdef SOUND_RETRIG_EN
  localparam bit RETRIG_ON = 1'b1;
`else
  localparam bit RETRIG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] code_sound;
  logic       mute;
  logic       retrig;
  logic       speaker;
  logic       busy;
  logic [1:0] cur_code;

  sound_player #(
    .PING_HALF(PH),
    .PONG_HALF(QH),
    .DUR_CYC(DUR),
    .GAP_CYC(GAP)
  ) dut (
    .clk(clk),
    .clr(clr),
    .code_sound(code_sound),
    .mute(mute),
    .speaker(speaker),
    .busy(busy),
    .cur_code(cur_code)
`ifdef SOUND_RETRIG_EN
    ,
    .retrig(retrig)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       spk;
    logic       busy;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which sequence is playing and how many cycles into it.
  int   m_code_q = 0;
  bit   m_act    = 1'b0;
  int   m_seq    = 0;
  int   m_off    = 0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int seq_len(input int c);
    return (c == 3) ? (2 * DUR + GAP) : DUR;
  endfunction

  function automatic bit tone_at(input int c, input int off);
    int half;
    int p;
    if (c == 3) begin
      if (off < DUR) begin half = QH; p = off; end
      else if (off < DUR + GAP) return 1'b0;
      else begin half = PH; p = off - DUR - GAP; end
    end else begin
      half = (c == 2) ? PH : QH;
      p = off;
    end
    return bit'((p / half) % 2);
  endfunction

  task automatic step(input int c, input bit m, input bit r);
    bit   trig;
    exp_t e;
    @(negedge clk);
    code_sound = 2'(c);
    mute       = m;
    retrig     = r;
    trig = (c != 0) && ((c != m_code_q) || (RETRIG_ON && r));
    if (trig) begin
      m_act = 1'b1; m_seq = c; m_off = 0;
    end else if (c == 0 && m_code_q != 0) begin
      m_act = 1'b0;
    end else if (m_act) begin
      m_off++;
      if (m_off >= seq_len(m_seq)) m_act = 1'b0;
    end
    m_code_q = c;
    if (m_act) begin
      e.busy = 1'b1;
      e.code = 2'(m_seq);
      e.spk  = tone_at(m_seq, m_off) & ~m;
    end else begin
      e.busy = 1'b0;
      e.code = 2'b00;
      e.spk  = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input int c, input bit m, input int n);
    for (int i = 0; i < n; i++) step(c, m, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("speaker",  {1'b0, speaker}, {1'b0, e.spk});
        chk("busy",     {1'b0, busy},    {1'b0, e.busy});
        chk("cur_code", cur_code,        e.code);
      end
    end
  end

  initial begin : stim
    clr = 1'b0; code_sound = 2'b00; mute = 1'b0; retrig = 1'b0;
    #1;
    chk("reset_speaker",  {1'b0, speaker}, 2'b00);
    chk("reset_busy",     {1'b0, busy},    2'b00);
    chk("reset_cur_code", cur_code,        2'b00);
    repeat (3) @(negedge clk);
    clr = 1'b1;

    hold(0, 1'b0, 3);
    hold(2, 1'b0, 26);                       // single ping, held: no replay
    hold(0, 1'b0, 2);
    hold(3, 1'b0, 52);                       // go: tone, gap, tone
    hold(0, 1'b0, 2);
    hold(2, 1'b0, 10);                       // ping preempted by pong
    hold(1, 1'b0, 24);
    hold(0, 1'b0, 2);
    hold(2, 1'b1, 24);                       // muted ping
    hold(0, 1'b0, 2);
    hold(2, 1'b0, 8);                        // ping cut short by stop
    hold(0, 1'b0, 4);
    hold(2, 1'b0, 24);                       // retrig replays (only if enabled)
    step(2, 1'b0, 1'b1);
    hold(2, 1'b0, 24);
    hold(0, 1'b0, 2);
    hold(3, 1'b0, 2);                        // go preempted right at gap boundary
    hold(3, 1'b0, 18);
    hold(2, 1'b0, 3);

    for (int i = 0; i < 800; i++) begin
      int c;
      c = m_code_q;
      if ($urandom_range(11, 0) == 0) c = int'($urandom_range(3, 0));
      step(c, bit'($urandom_range(3, 0) == 0), bit'($urandom_range(15, 0) == 0));
    end

    // Asynchronous reset in the middle of a ping.
    hold(0, 1'b0, 2);
    hold(2, 1'b0, 7);
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    chk("async_speaker",  {1'b0, speaker}, 2'b00);
    chk("async_busy",     {1'b0, busy},    2'b00);
    chk("async_cur_code", cur_code,        2'b00);
    m_act = 1'b0; m_code_q = 0;
    @(negedge clk);
    code_sound = 2'b00;
    @(negedge clk);
    clr = 1'b1;
    hold(0, 1'b0, 5);                        // stays idle after release
    hold(1, 1'b0, 22);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 2'(exp_q.size() != 0), 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
